// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Streams a program image into instruction memory and holds the core in
//   reset until the image is complete. It replaces a simulation-only preload,
//   so the same image path works on hardware.
//
//   Stream format: N[7:0], N[15:8], then 4*N data bytes, with the least
//   significant byte of each word first. Words are written to addresses
//   0..N-1 in order.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   start               load request; honoured in IDLE, DONE or ERROR
//   rx_data/valid/ready byte stream handshake (accept = valid && ready)
//   imem_we/addr/wdata  one-cycle instruction-memory write per word
//   core_reset          core reset; low only in DONE
//   busy/done/error     status flags (LEN_LO/LEN_HI/DATA, DONE, ERROR)
//
//   All outputs are registered.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_asm;       // the low three bytes of the word being assembled
    logic                  r_last;      // the final word's write cycle is in progress

    logic                  r_rx_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_core_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_accept;
    logic [15:0]           w_len;
    logic                  w_last_word;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_len       = {rx_data, r_len[7:0]};
    assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_last       <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address and data hold.
            r_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state      <= S_LEN_LO;
                        r_rx_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_core_reset <= 1'b1;
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (w_len == 16'd0) begin
                            r_state      <= S_DONE;
                            r_rx_ready   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else if (17'(w_len) > DEPTH) begin
                            r_state    <= S_ERROR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state    <= S_DATA;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_last     <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (r_last) begin
                        // Release the core only after the final write cycle,
                        // so a write never overlaps the release.
                        r_state      <= S_DONE;
                        r_last       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b0;
                    end else if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= rx_data;
                            2'd1: r_asm[15:8]  <= rx_data;
                            2'd2: r_asm[23:16] <= rx_data;
                            default: begin
                                // The fourth byte goes straight to the write
                                // data, so it never has to sit in r_asm.
                                r_we       <= 1'b1;
                                r_addr     <= r_word_idx;
                                r_wdata    <= {rx_data, r_asm};
                                r_word_idx <= r_word_idx + 1'b1;
                                if (w_last_word) begin
                                    r_last     <= 1'b1;
                                    r_rx_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, core_reset, busy, done, error;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;

    int total = 0;
    int bad = 0;

    imem_boot_loader #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // {rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error}
    typedef struct packed {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic [43:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [43:0] pk(input logic rr, input logic we, input logic [5:0] a,
                                       input logic [31:0] wd, input logic cr, input logic b,
                                       input logic dn, input logic er);
        return {rr, we, a, wd, cr, b, dn, er};
    endfunction

    function automatic logic [43:0] outs();
        return {rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error};
    endfunction

    task automatic add(input logic st, input logic vld, input logic [7:0] d, input logic [43:0] e);
        vec_t v;
        v.st = st; v.vld = vld; v.dat = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive inputs mid-cycle, let one rising edge happen, sample shortly after it.
    task automatic cyc(input logic st, input logic vld, input logic [7:0] d, input logic rst);
        @(negedge clk);
        start = st; rx_valid = vld; rx_data = d; reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [43:0] act, input logic [43:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, 1'b0);
    endtask

    localparam logic [31:0] W0 = 32'h00A00513;
    localparam logic [31:0] W1 = 32'h00500593;

    initial begin
        logic [43:0] rstv;
        int          cr_bad;
        logic [31:0] w;
        rstv = pk(0, 0, 6'd0, 32'h0, 1, 0, 0, 0);

        // Test 1: two-word load
        add(1, 0, 8'h00, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'h02, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'h13, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'h05, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'hA0, pk(1, 0, 0, 32'h0, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(1, 1, 0, W0, 1, 1, 0, 0));
        add(0, 1, 8'h93, pk(1, 0, 0, W0, 1, 1, 0, 0));
        add(0, 1, 8'h05, pk(1, 0, 0, W0, 1, 1, 0, 0));
        add(0, 1, 8'h50, pk(1, 0, 0, W0, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(0, 1, 1, W1, 1, 1, 0, 0));
        add(0, 1, 8'hFF, pk(0, 0, 1, W1, 0, 0, 1, 0));
        add(0, 1, 8'hFF, pk(0, 0, 1, W1, 0, 0, 1, 0));
        // Test 2: N=0 from DONE
        add(1, 0, 8'h00, pk(1, 0, 1, W1, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(1, 0, 1, W1, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(0, 0, 1, W1, 0, 0, 1, 0));
        // Test 3: N=65 overflows 64-word memory
        add(1, 0, 8'h00, pk(1, 0, 1, W1, 1, 1, 0, 0));
        add(0, 1, 8'h41, pk(1, 0, 1, W1, 1, 1, 0, 0));
        add(0, 1, 8'h00, pk(0, 0, 1, W1, 1, 0, 0, 1));
        add(0, 1, 8'h55, pk(0, 0, 1, W1, 1, 0, 0, 1));
        add(0, 1, 8'h66, pk(0, 0, 1, W1, 1, 0, 0, 1));
        add(1, 0, 8'h00, pk(1, 0, 1, W1, 1, 1, 0, 0));

        // Reset
        cyc(1'b1, 1'b1, 8'hAA, 1'b1);
        chk("reset", outs(), rstv);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_hold", outs(), rstv);

        foreach (vecs[i]) begin
            cyc(vecs[i].st, vecs[i].vld, vecs[i].dat, 1'b0);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Test 4: N=1 with a 5-cycle stall between bytes 2 and 3 (in LEN_LO now)
        send(8'h01);
        send(8'h00);
        send(8'hEF);
        send(8'hBE);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'hAD, 1'b0);
            chk1($sformatf("stall_we%0d", k), {31'd0, imem_we}, 32'd0);
        end
        send(8'hAD);
        chk1("stall_no_early_we", {31'd0, imem_we}, 32'd0);
        send(8'hDE);
        chk("stall_write", outs(), pk(0, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0));
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_done", outs(), pk(0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0));

        // Test 5: reset in the middle of DATA after 6 data bytes
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h03);
        send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("mid_first_write", outs(), pk(1, 1, 0, 32'h04030201, 1, 1, 0, 0));
        send(8'h05); send(8'h06);
        cyc(1'b1, 1'b1, 8'h07, 1'b1);
        chk("mid_reset", outs(), rstv);
        cyc(1'b0, 1'b1, 8'h07, 1'b0);
        chk("idle_no_consume", outs(), rstv);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("reload_write", outs(), pk(0, 1, 0, 32'h44332211, 1, 1, 0, 0));
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reload_done", outs(), pk(0, 0, 0, 32'h44332211, 0, 0, 1, 0));

        // Test 6: full 64-word load from DONE
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("full_start", outs(), pk(1, 0, 0, 32'h44332211, 1, 1, 0, 0));
        send(8'h40); send(8'h00);
        cr_bad = 0;
        for (int n = 0; n < 64; n++) begin
            w = 32'hC0DE0000 + 32'(n);
            for (int b = 0; b < 4; b++) begin
                send(w[8*b +: 8]);
                if (core_reset !== 1'b1) cr_bad++;
            end
            chk1($sformatf("full_we%0d", n), {31'd0, imem_we}, 32'd1);
            chk1($sformatf("full_addr%0d", n), {26'd0, imem_addr}, 32'(n));
            chk1($sformatf("full_data%0d", n), imem_wdata, w);
        end
        chk1("full_core_reset_held", 32'(cr_bad), 32'd0);
        chk("full_last_cycle", outs(), pk(0, 1, 63, 32'hC0DE003F, 1, 1, 0, 0));
        cyc(1'b0, 1'b1, 8'h99, 1'b0);
        chk("full_done", outs(), pk(0, 0, 63, 32'hC0DE003F, 0, 0, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
